// File: rtl/varredura_linhas.sv
// -----------------------------------------------------------------------------
// varredura_linhas
// Row-scan controller for the 5x7 LED matrix.
//
// Every row slot lasts DIV_LINHA clock cycles. The first BLANK cycles are
// blanked: all rows are off and apagar=1, while contador already shows the
// row about to be lit so the column pattern can settle. The remaining cycles
// drive that row low. After row 6 the scan wraps back to row 0, and the frame
// index may advance. In auto mode it advances every VARREDURAS_POR_QUADRO
// scans. In manual mode it advances on a pending proximo request.
//
// Ports:
//   clk           in   system clock
//   reset         in   asynchronous active-high reset
//   habilita      in   scan enable; low parks the controller in IDLE
//   modo_auto     in   1 = timed frame advance, 0 = manual advance
//   proximo       in   single-cycle manual frame-advance request
//   contador      out  current row index 0..6 (feeds quadro_N)
//   linhas        out  active-low one-hot row enables
//   apagar        out  1 = downstream forces columns off
//   quadro_sel    out  current frame index 0..N_QUADROS-1
//   fim_varredura out  1-cycle pulse on row wrap 6->0
//   fim_quadro    out  1-cycle pulse on a frame advance
// -----------------------------------------------------------------------------
module varredura_linhas #(
    parameter int DIV_LINHA             = 50000,
    parameter int BLANK                 = 4,
    parameter int N_QUADROS             = 8,
    parameter int VARREDURAS_POR_QUADRO = 100
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       habilita,
    input  logic       modo_auto,
    input  logic       proximo,
    output logic [2:0] contador,
    output logic [6:0] linhas,
    output logic       apagar,
    output logic [2:0] quadro_sel,
    output logic       fim_varredura,
    output logic       fim_quadro
);

    localparam int PW = (DIV_LINHA > 1) ? $clog2(DIV_LINHA) : 1;
    localparam int SW = $clog2(VARREDURAS_POR_QUADRO + 1);

    localparam logic [PW-1:0] P_MAX   = PW'(DIV_LINHA - 1);
    localparam logic [PW-1:0] P_BLANK = PW'(BLANK);
    localparam logic [SW-1:0] S_MAX   = SW'(VARREDURAS_POR_QUADRO - 1);
    localparam logic [2:0]    Q_MAX   = 3'(N_QUADROS - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_ATIVO = 2'd2
    } estado_t;

    estado_t         estado_r;
    estado_t         estado_s;
    logic [PW-1:0]   p_r;
    logic [PW-1:0]   p_s;
    logic [SW-1:0]   s_r;
    logic [SW-1:0]   s_s;
    logic            pendente_r;
    logic            pendente_s;
    logic            modo_auto_r;
    logic [2:0]      contador_s;
    logic [6:0]      linhas_s;
    logic            apagar_s;
    logic [2:0]      quadro_s;
    logic            fim_varredura_s;
    logic            fim_quadro_s;
    logic            modo_mudou_s;
    logic            pendente_ef_s;
    logic            wrap_s;

    // Next-state, frame sequencing and next-output computation.
    always_comb begin
        estado_s        = estado_r;
        p_s             = p_r;
        s_s             = s_r;
        pendente_s      = pendente_r;
        contador_s      = contador;
        quadro_s        = quadro_sel;
        fim_varredura_s = 1'b0;
        fim_quadro_s    = 1'b0;
        linhas_s        = 7'h7F;
        apagar_s        = 1'b1;

        // A mode change throws away any request made under the old mode.
        modo_mudou_s  = (modo_auto != modo_auto_r);
        pendente_ef_s = pendente_r & ~modo_mudou_s;

        wrap_s = habilita && (estado_r != ST_IDLE) && (p_r == P_MAX)
                 && (contador == 3'd6);

        // Manual request bookkeeping. A request that coincides with a wrap
        // is not consumed by that wrap. It waits for the next one.
        if (!habilita || modo_auto || modo_mudou_s) begin
            pendente_s = 1'b0;
        end else if (wrap_s) begin
            pendente_s = proximo;
        end else begin
            pendente_s = pendente_r | proximo;
        end

        case (estado_r)
            ST_IDLE: begin
                p_s        = {PW{1'b0}};
                contador_s = 3'd0;
                if (habilita) begin
                    estado_s = ST_BLANK;
                end else begin
                    estado_s = ST_IDLE;
                end
            end
            ST_BLANK, ST_ATIVO: begin
                if (!habilita) begin
                    estado_s   = ST_IDLE;
                    p_s        = {PW{1'b0}};
                    contador_s = 3'd0;
                end else begin
                    if (p_r == P_MAX) begin
                        p_s = {PW{1'b0}};
                        if (contador == 3'd6) begin
                            contador_s      = 3'd0;
                            fim_varredura_s = 1'b1;
                            if (modo_auto) begin
                                if (s_r == S_MAX) begin
                                    s_s          = {SW{1'b0}};
                                    fim_quadro_s = 1'b1;
                                    quadro_s     = (quadro_sel == Q_MAX) ? 3'd0 : quadro_sel + 3'd1;
                                end else begin
                                    s_s = s_r + 1'b1;
                                end
                            end else if (pendente_ef_s) begin
                                s_s          = {SW{1'b0}};
                                fim_quadro_s = 1'b1;
                                quadro_s     = (quadro_sel == Q_MAX) ? 3'd0 : quadro_sel + 3'd1;
                            end else begin
                                s_s = (s_r == S_MAX) ? {SW{1'b0}} : s_r + 1'b1;
                            end
                        end else begin
                            contador_s = contador + 3'd1;
                        end
                    end else begin
                        p_s = p_r + 1'b1;
                    end
                    // The phase inside the slot follows from the prescaler alone.
                    if (p_s < P_BLANK) begin
                        estado_s = ST_BLANK;
                    end else begin
                        estado_s = ST_ATIVO;
                    end
                end
            end
            default: begin
                estado_s   = ST_IDLE;
                p_s        = {PW{1'b0}};
                contador_s = 3'd0;
            end
        endcase

        // Decode the row drive from the next state so the outputs stay registered.
        if (estado_s == ST_ATIVO) begin
            linhas_s = ~(7'd1 << contador_s);
            apagar_s = 1'b0;
        end else begin
            linhas_s = 7'h7F;
            apagar_s = 1'b1;
        end
    end

    // State, counter and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            estado_r      <= ST_IDLE;
            p_r           <= {PW{1'b0}};
            s_r           <= {SW{1'b0}};
            pendente_r    <= 1'b0;
            modo_auto_r   <= 1'b0;
            contador      <= 3'd0;
            linhas        <= 7'h7F;
            apagar        <= 1'b1;
            quadro_sel    <= 3'd0;
            fim_varredura <= 1'b0;
            fim_quadro    <= 1'b0;
        end else begin
            estado_r      <= estado_s;
            p_r           <= p_s;
            s_r           <= s_s;
            pendente_r    <= pendente_s;
            modo_auto_r   <= modo_auto;
            contador      <= contador_s;
            linhas        <= linhas_s;
            apagar        <= apagar_s;
            quadro_sel    <= quadro_s;
            fim_varredura <= fim_varredura_s;
            fim_quadro    <= fim_quadro_s;
        end
    end

endmodule
